// File: rtl/pmem_arbiter_rr.sv
// pmem_arbiter_rr: N-way arbiter from cache requesters onto the single physical memory port.
// One access in flight; round-robin or fixed priority; sticky watchdog flag for hung accesses.
//
// state   | meaning
// IDLE    | nothing in flight; pick a winner among pending requesters
// BUSY    | granted requester drives pmem until pmem_resp
// RELEASE | dead cycle so the finished requester can drop its strobes
module pmem_arbiter_rr #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 128,
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_resp,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          pmem_read,
    output logic                          pmem_write,
    output logic [ADDR_WIDTH-1:0]         pmem_address,
    output logic [DATA_WIDTH-1:0]         pmem_wdata,
    input  logic [DATA_WIDTH-1:0]         pmem_rdata,
    input  logic                          pmem_resp,
    output logic                          busy,
    output logic [GW-1:0]                 grant_id,
    output logic                          err_timeout
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES);

    logic [1:0]         state;
    logic [GW-1:0]      rr_ptr;
    logic [GW-1:0]      rr_next;
    logic [GW-1:0]      winner;
    logic [WDW-1:0]     wd_cnt;
    logic [NUM_REQ-1:0] pending;
    logic               g_read;
    logic               g_write;
    logic               g_active;
    int                 search_start;
    int                 search_idx;
    logic               search_found;

    assign pending = req_read | req_write;

    always_comb begin
        winner       = '0;
        search_found = 1'b0;
        search_idx   = 0;
        search_start = (FIXED_PRIO != 0) ? 0 : int'(rr_ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            search_idx = (search_start + k) % NUM_REQ;
            if (!search_found && pending[search_idx[GW-1:0]]) begin
                winner       = search_idx[GW-1:0];
                search_found = 1'b1;
            end
        end
    end

    assign rr_next = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

    // strobes follow the granted requester live, so an early drop aborts immediately
    assign g_read     = req_read[grant_id];
    assign g_write    = req_write[grant_id];
    assign busy       = (state == S_BUSY);
    assign g_active   = busy && (g_read || g_write);
    assign pmem_write = busy & g_write;
    assign pmem_read  = busy & g_read & ~g_write;
    assign req_rdata  = pmem_rdata;

    always_comb begin
        pmem_address = req_address[ADDR_WIDTH-1:0];
        pmem_wdata   = req_wdata[DATA_WIDTH-1:0];
        for (int i = 1; i < NUM_REQ; i++) begin
            if (int'(grant_id) == i) begin
                pmem_address = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                pmem_wdata   = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        req_resp = '0;
        if (g_active && pmem_resp) begin
            req_resp[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|pending) begin
                        grant_id <= winner;
                        wd_cnt   <= '0;
                        state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!g_active) begin
                        state <= S_IDLE;
                    end else if (pmem_resp) begin
                        state <= S_RELEASE;
                    end else if (TIMEOUT_CYCLES != 0 && wd_cnt != WD_LIMIT) begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (wd_cnt + 1'b1 == WD_LIMIT) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                S_RELEASE: begin
                    rr_ptr <= rr_next;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pmem_arbiter_rr.sv
// Bench for pmem_arbiter_rr: directed protocol scenarios plus a randomized phase whose
// grants and completions are predicted by a transaction-level round-robin model.
module tb_pmem_arbiter_rr;
    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_read = '0;
    logic [NR-1:0]   req_write = '0;
    logic [NR*AW-1:0] req_address = {16'h3333, 16'h2222, 16'h1111, 16'hBEEF};
    logic [NR*DW-1:0] req_wdata = '0;
    logic [DW-1:0]   pmem_rdata = '0;
    logic            pmem_resp = 1'b0;

    logic [NR-1:0]   req_resp, fx_req_resp;
    logic [DW-1:0]   req_rdata, fx_req_rdata, pmem_wdata, fx_pmem_wdata;
    logic            pmem_read, pmem_write, busy, err_timeout;
    logic            fx_pmem_read, fx_pmem_write, fx_busy, fx_err_timeout;
    logic [AW-1:0]   pmem_address, fx_pmem_address;
    logic [1:0]      grant_id, fx_grant_id;

    int n_checks = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;
    bit prev_strobe = 1'b0;

    typedef struct { int id; logic [AW-1:0] a; logic rd; logic wr; logic [DW-1:0] d; } gnt_t;
    typedef struct { int id; logic [DW-1:0] d; } rsp_t;
    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    gnt_t ge;
    rsp_t re;

    pmem_arbiter_rr #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0),
                      .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata), .req_resp(req_resp),
        .req_rdata(req_rdata), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout));

    // fixed-priority twin shares all inputs; only checked while every requester is pending
    pmem_arbiter_rr #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1),
                      .TIMEOUT_CYCLES(TO)) dut_fx (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata), .req_resp(fx_req_resp),
        .req_rdata(fx_req_rdata), .pmem_read(fx_pmem_read), .pmem_write(fx_pmem_write),
        .pmem_address(fx_pmem_address), .pmem_wdata(fx_pmem_wdata), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .busy(fx_busy), .grant_id(fx_grant_id),
        .err_timeout(fx_err_timeout));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_read[i]            = rd;
        req_write[i]           = wr;
        req_address[i*AW +: AW] = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic clear_all();
        req_read  = '0;
        req_write = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        clear_all();
        pmem_resp = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic int rr_pick(input logic [NR-1:0] pend, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (pend[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    // scoreboard monitor: a grant is checked on the first strobe cycle, a completion on req_resp
    always @(negedge clk) begin
        if (mon_en) begin
            if ((pmem_read || pmem_write) && !prev_strobe) begin
                if (gnt_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected_grant: grant_id %0d, no grant expected", grant_id);
                end else begin
                    ge = gnt_q.pop_front();
                    chk("sb_grant_id", grant_id, ge.id);
                    chk("sb_address", pmem_address, ge.a);
                    chk("sb_pmem_read", pmem_read, ge.rd);
                    chk("sb_pmem_write", pmem_write, ge.wr);
                    if (ge.wr) chk("sb_wdata", pmem_wdata, ge.d);
                end
            end
            prev_strobe = pmem_read || pmem_write;
            if (req_resp != '0) begin
                if (rsp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected_resp: req_resp 0x%0h, no completion expected", req_resp);
                end else begin
                    re = rsp_q.pop_front();
                    chk("sb_req_resp", req_resp, 1 << re.id);
                    chk("sb_rdata", req_rdata, re.d);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int m_state, m_ptr, m_w, m_lat, m_cnt, cyc, kind;
        bit any_act;
        bit r_act[NR];
        bit r_done[NR];
        logic r_rd[NR];
        logic r_wr[NR];
        logic [AW-1:0] r_a[NR];
        logic [DW-1:0] r_d[NR];

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_req_resp", req_resp, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_addr_follows_req0", pmem_address, 16'hBEEF);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single request from requester 1, response three cycles after the request
        set_req(1, 1'b1, 1'b0, 16'h1234, 32'h0);
        @(negedge clk);
        chk("t1_idle_no_strobe", pmem_read, 0);
        step();
        @(negedge clk);
        chk("t1_pmem_read", pmem_read, 1);
        chk("t1_address", pmem_address, 16'h1234);
        chk("t1_grant_id", grant_id, 1);
        chk("t1_busy", busy, 1);
        step();
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = 32'hCAFE0001;
        @(negedge clk);
        chk("t1_req_resp", req_resp, 4'b0010);
        chk("t1_rdata", req_rdata, 32'hCAFE0001);
        step();
        pmem_resp = 1'b0;
        set_req(1, 1'b0, 1'b0, 16'h1234, 32'h0);
        @(negedge clk);
        chk("t1_release_busy", busy, 0);
        chk("t1_release_resp", req_resp, 0);
        step();

        // read and write together: write wins
        set_req(0, 1'b1, 1'b1, 16'h0400, 32'hAAAAAAAA);
        pmem_rdata = 32'h55AA55AA;
        step();
        @(negedge clk);
        chk("t3_pmem_write", pmem_write, 1);
        chk("t3_pmem_read", pmem_read, 0);
        chk("t3_wdata", pmem_wdata, 32'hAAAAAAAA);
        chk("t3_grant_id", grant_id, 0);
        chk("t3_rdata_tracks", req_rdata, 32'h55AA55AA);
        step();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("t3_req_resp", req_resp, 4'b0001);
        step();
        pmem_resp = 1'b0;
        clear_all();
        step();

        // round-robin fairness with all four reading continuously
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(16'h1000 + i), DW'(32'hF0 + i));
        pmem_rdata = 32'h00001357;
        for (int j = 1; j <= 17; j++) begin
            step();
            pmem_resp = (j % 3 == 1);
            if (j == 17) clear_all();
            @(negedge clk);
            if (j % 3 == 1) begin
                chk("rr_grant_id", grant_id, (j / 3) % NR);
                chk("rr_req_resp", req_resp, 1 << ((j / 3) % NR));
                chk("fx_grant_id", fx_grant_id, 0);
                chk("fx_req_resp", fx_req_resp, 4'b0001);
                if (j == 1) begin
                    chk("fx_busy", fx_busy, 1);
                    chk("fx_pmem_read", fx_pmem_read, 1);
                    chk("fx_pmem_write", fx_pmem_write, 0);
                    chk("fx_address", fx_pmem_address, 16'h1000);
                    chk("fx_wdata", fx_pmem_wdata, 32'hF0);
                    chk("fx_rdata", fx_req_rdata, 32'h00001357);
                    chk("fx_err", fx_err_timeout, 0);
                end
            end else begin
                chk("rr_gap_no_strobe", pmem_read, 0);
            end
        end

        // protocol violation: requester 2 drops strobes before its response
        step();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(16'h2000 + i), 32'h0);
        step();
        @(negedge clk);
        chk("t4_grant_id", grant_id, 2);
        chk("t4_pmem_read", pmem_read, 1);
        step();
        set_req(2, 1'b0, 1'b0, 16'h2002, 32'h0);
        @(negedge clk);
        chk("t4_drop_read", pmem_read, 0);
        chk("t4_drop_resp", req_resp, 0);
        chk("t4_drop_busy", busy, 1);
        step();
        set_req(2, 1'b1, 1'b0, 16'h2002, 32'h0);
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("t4_idle_busy", busy, 0);
        chk("t4_spurious_resp", req_resp, 0);
        step();
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("t4_regrant_id", grant_id, 2);
        chk("t4_regrant_addr", pmem_address, 16'h2002);
        step();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("t4_req_resp", req_resp, 4'b0100);
        step();
        pmem_resp = 1'b0;
        clear_all();
        step();

        // watchdog: response withheld for 20 BUSY cycles
        set_req(0, 1'b1, 1'b0, 16'h3000, 32'h0);
        for (int b = 1; b <= 20; b++) begin
            step();
            @(negedge clk);
            chk("wd_err_timeout", err_timeout, b >= 9);
        end
        step();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("wd_req_resp", req_resp, 4'b0001);
        step();
        pmem_resp = 1'b0;
        set_req(0, 1'b0, 1'b0, 16'h3000, 32'h0);
        @(negedge clk);
        chk("wd_err_sticky", err_timeout, 1);
        step();

        // asynchronous reset in the middle of a BUSY cycle
        set_req(3, 1'b1, 1'b0, 16'h4000, 32'h0);
        step();
        @(negedge clk);
        chk("t6_pmem_read", pmem_read, 1);
        chk("t6_grant_id", grant_id, 3);
        #1 pmem_resp = 1'b1;
        #1 chk("t6_resp_before_rst", req_resp, 4'b1000);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_read", pmem_read, 0);
        chk("t6_rst_resp", req_resp, 0);
        chk("t6_rst_err", err_timeout, 0);
        set_req(3, 1'b0, 1'b0, 16'h4000, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_idle_spurious_resp", req_resp, 0);
        step();
        @(negedge clk);
        chk("t6_idle_busy", busy, 0);
        step();
        pmem_resp = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(16'h5000 + i), 32'h0);
        step();
        @(negedge clk);
        chk("t6_ptr_reset_grant", grant_id, 0);
        step();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("t6_req_resp", req_resp, 4'b0001);
        step();
        pmem_resp = 1'b0;
        clear_all();

        // randomized phase against the transaction-level model
        do_reset();
        prev_strobe = 1'b0;
        mon_en  = 1'b1;
        m_state = 0;
        m_ptr   = 0;
        m_w     = 0;
        m_lat   = 1;
        m_cnt   = 0;
        for (int i = 0; i < NR; i++) begin
            r_act[i] = 1'b0;
            r_done[i] = 1'b0;
        end
        cyc = 0;
        while (cyc < 3000) begin
            any_act = 1'b0;
            for (int i = 0; i < NR; i++) any_act |= r_act[i];
            if (cyc >= 1500 && m_state == 0 && !any_act) break;
            step();
            pmem_resp  = 1'b0;
            pmem_rdata = $urandom();
            for (int i = 0; i < NR; i++) begin
                if (r_done[i]) begin
                    r_done[i] = 1'b0;
                    r_act[i]  = 1'b0;
                    set_req(i, 1'b0, 1'b0, r_a[i], r_d[i]);
                end else if (!r_act[i] && cyc < 1500 && $urandom_range(0, 2) == 0) begin
                    kind     = $urandom_range(0, 2);
                    r_rd[i]  = (kind != 1);
                    r_wr[i]  = (kind != 0);
                    r_a[i]   = AW'($urandom_range(0, 65535));
                    r_d[i]   = $urandom();
                    r_act[i] = 1'b1;
                    set_req(i, r_rd[i], r_wr[i], r_a[i], r_d[i]);
                end
            end
            case (m_state)
                0: begin
                    m_w = rr_pick(req_read | req_write, m_ptr);
                    if (m_w >= 0) begin
                        gnt_q.push_back('{m_w, r_a[m_w], r_rd[m_w] & ~r_wr[m_w], r_wr[m_w], r_d[m_w]});
                        m_cnt   = 0;
                        m_lat   = $urandom_range(1, 4);
                        m_state = 1;
                    end
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == m_lat) begin
                        pmem_resp = 1'b1;
                        rsp_q.push_back('{m_w, pmem_rdata});
                        r_done[m_w] = 1'b1;
                        m_state = 2;
                    end
                end
                default: begin
                    m_ptr   = (m_w + 1) % NR;
                    m_state = 0;
                end
            endcase
            cyc++;
        end
        repeat (3) step();
        mon_en = 1'b0;
        chk("sb_grants_drained", gnt_q.size(), 0);
        chk("sb_resps_drained", rsp_q.size(), 0);
        chk("sb_no_timeout", err_timeout, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
